quadrature_downconvert: RTL and testbench

Real-to-complex NCO mixer for the receive path. It multiplies a real ADC-rate sample stream by e^(−jωt) and produces baseband I/Q. It mirrors the transmit-side complex-to-real frequency translator, using the same 32-bit NCO, the same 14-bit phase-offset word, and the same quarter-wave sine/cosine scheme. It sits between the ADC capture stage and the decimation filters.

---
 rtl/dsp_pkg.sv | 34 +++
 rtl/quarter_wave_lut.sv | 29 ++
 rtl/quadrature_downconvert.sv | 141 ++++++++++++++
 tb/tb_quadrature_downconvert.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the NCO-based frequency translators (widths, quadrant
// encoding and the quarter-wave sine/cosine table generator).
`default_nettype none

package dsp_pkg;

  localparam int DATA_W     = 14;
  localparam int ACC_W      = 32;
  localparam int PHASE_W    = 14;
  localparam int LUT_ADDR_W = 12;
  localparam int LUT_PEAK   = 8191;
  localparam int LUT_W      = DATA_W - 1;
  localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;
  localparam int MIX_SHIFT  = LUT_W;

  typedef enum logic [1:0] {
    QUAD_0   = 2'd0,
    QUAD_90  = 2'd1,
    QUAD_180 = 2'd2,
    QUAD_270 = 2'd3
  } quadrant_t;

  // One table entry: round(PEAK * sin/cos(2*pi*addr / 2^PHASE_W)); always >= 0 in the first quadrant.
  function automatic logic [LUT_W-1:0] lut_init(input int addr, input bit is_cos);
    real angle;
    real val;
    angle = 2.0 * 3.14159265358979323846 * real'(addr) / real'(1 << PHASE_W);
    val   = is_cos ? $cos(angle) : $sin(angle);
    return LUT_W'($rtoi(real'(LUT_PEAK) * val + 0.5));
  endfunction

endpackage

`default_nettype wire

// File: rtl/quarter_wave_lut.sv
// Dual-output quarter-wave sine/cosine ROM with a single registered read stage.
`default_nettype none

module quarter_wave_lut
  import dsp_pkg::*;
(
  input  logic                  clk,
  input  logic [LUT_ADDR_W-1:0] i_addr,
  output logic [LUT_W-1:0]      o_sin,
  output logic [LUT_W-1:0]      o_cos
);

  logic [LUT_W-1:0] w_sin_rom [LUT_DEPTH];
  logic [LUT_W-1:0] w_cos_rom [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    assign w_sin_rom[g] = lut_init(g, 1'b0);
    assign w_cos_rom[g] = lut_init(g, 1'b1);
  end

  // No reset on the read register so the table maps onto block RAM.
  always_ff @(posedge clk) begin
    o_sin <= w_sin_rom[i_addr];
    o_cos <= w_cos_rom[i_addr];
  end

endmodule

`default_nettype wire

// File: rtl/quadrature_downconvert.sv
// Real-to-complex NCO mixer: multiplies the real ADC stream by e^(-jwt) to give
// baseband I/Q, five cycles of latency, one sample per clock, no stalls.
`default_nettype none

module quadrature_downconvert
  import dsp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  real_in,
  input  logic                      in_valid,
  input  logic        [ACC_W-1:0]   frequency,
  input  logic                      frequency_en,
  input  logic        [PHASE_W-1:0] frequency_mod,
  input  logic                      phase_clr,
  output logic signed [DATA_W-1:0]  i_out,
  output logic signed [DATA_W-1:0]  q_out,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  sine,
  output logic signed [DATA_W-1:0]  cosine
);

  logic        [ACC_W-1:0]     r_phase_accum;
  logic        [ACC_W-1:0]     r_frequency;
  logic        [ACC_W-1:0]     w_acc_cur;
  logic        [PHASE_W-1:0]   w_phase;

  logic signed [DATA_W-1:0]    r_x0, r_x1, r_x2;
  logic        [PHASE_W-1:0]   r_p0;
  quadrant_t                   r_quad1;
  logic                        r_v0, r_v1, r_v2, r_v3;

  logic        [LUT_W-1:0]     w_lut_sin, w_lut_cos;
  logic signed [DATA_W-1:0]    w_s_pos, w_c_pos, w_sine, w_cosine;

  logic signed [2*DATA_W-1:0]  w_x_ext, w_sin_ext, w_cos_ext, w_prod_i, w_prod_q;
  logic signed [DATA_W-1:0]    r_prod_i, r_prod_q;
  logic                        w_unused;

  // A restart zeroes the phase seen by this sample as well as the stored one.
  assign w_acc_cur = phase_clr ? '0 : r_phase_accum;
  assign w_phase   = w_acc_cur[ACC_W-1 -: PHASE_W] + frequency_mod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase_accum <= '0;
      r_frequency   <= '0;
      r_x0          <= '0;
      r_p0          <= '0;
      r_v0          <= 1'b0;
    end else begin
      r_phase_accum <= in_valid ? (w_acc_cur + r_frequency) : w_acc_cur;
      if (frequency_en) begin
        r_frequency <= frequency;
      end
      r_x0 <= real_in;
      r_p0 <= w_phase;
      r_v0 <= in_valid;
    end
  end

  quarter_wave_lut u_lut (
    .clk    (clk),
    .i_addr (r_p0[LUT_ADDR_W-1:0]),
    .o_sin  (w_lut_sin),
    .o_cos  (w_lut_cos)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quad1 <= QUAD_0;
      r_x1    <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_quad1 <= quadrant_t'(r_p0[PHASE_W-1 -: 2]);
      r_x1    <= r_x0;
      r_v1    <= r_v0;
    end
  end

  assign w_s_pos = signed'({1'b0, w_lut_sin});
  assign w_c_pos = signed'({1'b0, w_lut_cos});

  always_comb begin
    w_sine   = '0;
    w_cosine = '0;
    case (r_quad1)
      QUAD_0:   begin w_sine =  w_s_pos; w_cosine =  w_c_pos; end
      QUAD_90:  begin w_sine =  w_c_pos; w_cosine = -w_s_pos; end
      QUAD_180: begin w_sine = -w_s_pos; w_cosine = -w_c_pos; end
      QUAD_270: begin w_sine = -w_c_pos; w_cosine =  w_s_pos; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sine   <= '0;
      cosine <= '0;
      r_x2   <= '0;
      r_v2   <= 1'b0;
    end else begin
      sine   <= w_sine;
      cosine <= w_cosine;
      r_x2   <= r_x1;
      r_v2   <= r_v1;
    end
  end

  assign w_x_ext   = {{DATA_W{r_x2[DATA_W-1]}}, r_x2};
  assign w_sin_ext = {{DATA_W{sine[DATA_W-1]}}, sine};
  assign w_cos_ext = {{DATA_W{cosine[DATA_W-1]}}, cosine};
  assign w_prod_i  = w_x_ext * w_cos_ext;
  assign w_prod_q  = -(w_x_ext * w_sin_ext);

  // |sine|,|cosine| <= PEAK keeps the floored result inside DATA_W, so the top bit is redundant.
  assign w_unused = ^{w_prod_i[2*DATA_W-1], w_prod_i[MIX_SHIFT-1:0],
                      w_prod_q[2*DATA_W-1], w_prod_q[MIX_SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod_i  <= '0;
      r_prod_q  <= '0;
      r_v3      <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      r_prod_i  <= w_prod_i[MIX_SHIFT +: DATA_W];
      r_prod_q  <= w_prod_q[MIX_SHIFT +: DATA_W];
      r_v3      <= r_v2;
      out_valid <= r_v3;
      if (r_v3) begin
        i_out <= r_prod_i;
        q_out <= r_prod_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quadrature_downconvert.sv
// Directed self-checking bench for quadrature_downconvert.
`default_nettype none

module tb_quadrature_downconvert;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [13:0] real_in;
  logic               in_valid;
  logic        [31:0] frequency;
  logic               frequency_en;
  logic        [13:0] frequency_mod;
  logic               phase_clr;
  logic signed [13:0] i_out;
  logic signed [13:0] q_out;
  logic               out_valid;
  logic signed [13:0] sine;
  logic signed [13:0] cosine;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          v;
    bit          clr;
    bit          fen;
    logic [31:0] freq;
    bit          chk;
    int          ei;
    int          eq;
  } vec_t;

  vec_t vecs[16];

  quadrature_downconvert dut (
    .clk           (clk),
    .rst           (rst),
    .real_in       (real_in),
    .in_valid      (in_valid),
    .frequency     (frequency),
    .frequency_en  (frequency_en),
    .frequency_mod (frequency_mod),
    .phase_clr     (phase_clr),
    .i_out         (i_out),
    .q_out         (q_out),
    .out_valid     (out_valid),
    .sine          (sine),
    .cosine        (cosine)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(bit v, bit clr, bit fen, logic [31:0] freq, bit chk, int ei, int eq);
    vec_t t;
    t.v = v; t.clr = clr; t.fen = fen; t.freq = freq; t.chk = chk; t.ei = ei; t.eq = eq;
    return t;
  endfunction

  // Drives vecs[0..n-1] with x = 8191; output for vector k is visible after tick k+4.
  task automatic run_vec(input string name, input int n);
    bit have_last = 1'b0;
    int last_i = 0;
    int last_q = 0;
    for (int m = 0; m < n + 4; m++) begin
      real_in = 14'sd8191;
      if (m < n) begin
        in_valid = vecs[m].v; phase_clr = vecs[m].clr;
        frequency_en = vecs[m].fen; frequency = vecs[m].freq;
      end else begin
        in_valid = 1'b0; phase_clr = 1'b0; frequency_en = 1'b0; frequency = '0;
      end
      tick();
      if (m >= 4) begin
        int k = m - 4;
        check($sformatf("%s_valid[%0d]", name, k), int'(out_valid), int'(vecs[k].v));
        if (vecs[k].v && vecs[k].chk) begin
          check($sformatf("%s_i[%0d]", name, k), int'(i_out), vecs[k].ei);
          check($sformatf("%s_q[%0d]", name, k), int'(q_out), vecs[k].eq);
          have_last = 1'b1; last_i = vecs[k].ei; last_q = vecs[k].eq;
        end else if (!vecs[k].v && have_last) begin
          check($sformatf("%s_hold_i[%0d]", name, k), int'(i_out), last_i);
          check($sformatf("%s_hold_q[%0d]", name, k), int'(q_out), last_q);
        end
      end
    end
  endtask

  initial begin
    int fi[4] = '{8190, 0, -8191, 0};
    int fq[4] = '{0, -8191, 0, 8190};

    rst = 1'b0; in_valid = 1'b1; real_in = 14'sd4000; frequency = '0;
    frequency_en = 1'b1; frequency_mod = '0; phase_clr = 1'b0;
    repeat (3) tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_i", int'(i_out), 0);
    check("rst_q", int'(q_out), 0);
    check("rst_sine", int'(sine), 0);
    check("rst_cosine", int'(cosine), 0);

    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("latency_valid[%0d]", k), int'(out_valid), (k == 5) ? 1 : 0);
    end
    check("dc_i", int'(i_out), 3999);
    check("dc_q", int'(q_out), 0);
    check("dc_sine", int'(sine), 0);
    check("dc_cosine", int'(cosine), 8191);

    real_in = -14'sd5000;
    repeat (5) tick();
    check("dc_neg_i", int'(i_out), -5000);
    check("dc_neg_q", int'(q_out), 0);

    real_in = 14'sd4000; frequency_mod = 14'd4096;
    repeat (6) tick();
    check("off90_sine", int'(sine), 8191);
    check("off90_cosine", int'(cosine), 0);
    check("off90_i", int'(i_out), 0);
    check("off90_q", int'(q_out), -4000);
    frequency_mod = '0;

    vecs[0] = mk(1'b0, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 0, 0);
    for (int k = 1; k <= 8; k++) vecs[k] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, fi[(k-1)%4], fq[(k-1)%4]);
    run_vec("fs4", 9);

    vecs[0] = mk(1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 8190, 0);
    vecs[2] = mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
    vecs[3] = mk(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 0, -8191);
    vecs[5] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, -8191, 0);
    run_vec("gap", 6);

    vecs[0] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 0, 8190);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 32'h2000_0000, 1'b1, 8190, 0);
    vecs[2] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 0, -8191);
    vecs[3] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, -5792, -5792);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, '0, 1'b1, -8191, 0);
    run_vec("ctl", 5);

    real_in = 14'sd4000; in_valid = 1'b1;
    repeat (6) tick();
    check("mid_pre_valid", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_i", int'(i_out), 0);
    tick();
    rst = 1'b1; frequency_mod = 14'd4096; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("post_rst_early", int'(out_valid), 0);
    tick();
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_i", int'(i_out), 0);
    check("post_rst_q", int'(q_out), -4000);
    tick();
    check("post_rst_drop", int'(out_valid), 0);
    check("post_rst_hold_q", int'(q_out), -4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
